// File: rtl/timer_ctrl.sv
// timer_ctrl: sequencer for a cascaded decimal down-counting digit chain.
// Drives the LSD decrement tick, the reload strobe to all digits and the expiry alarm.
// Optional build macro: AUTO_RELOAD_EN (alarm completion reloads and restarts the countdown).
module timer_ctrl #(
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       clear_btn,
    input  logic       zero_in,
    output logic       tick_out,
    output logic       reconfig_out,
    output logic       alarm,
    output logic       running,
    output logic [1:0] state
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ALM_W = $clog2(ALARM_TICKS + 1);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_TICKS - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [ALM_W-1:0] alm_cnt_q, alm_cnt_d;
    logic             tick_q, tick_d;
    logic             reconfig_q, reconfig_d;
    logic             alarm_q, alarm_d;
    logic             running_q, running_d;
    logic             start_btn_q, start_btn_d;
    logic             pause_btn_q, pause_btn_d;
    logic             clear_btn_q, clear_btn_d;

    logic             start_ev_c, pause_ev_c, clear_ev_c;
    logic             pre_wrap_c;
    logic [PRE_W-1:0] pre_inc_c;

    // Button rising-edge events and prescaler step
    always_comb begin
        start_ev_c = start_btn & ~start_btn_q;
        pause_ev_c = pause_btn & ~pause_btn_q;
        clear_ev_c = clear_btn & ~clear_btn_q;
        pre_wrap_c = (pre_q == PRE_MAX);
        pre_inc_c  = pre_wrap_c ? '0 : pre_q + PRE_W'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        alm_cnt_d   = alm_cnt_q;
        tick_d      = 1'b0;
        reconfig_d  = 1'b0;
        start_btn_d = start_btn;
        pause_btn_d = pause_btn;
        clear_btn_d = clear_btn;

        case (state_q)
            S_IDLE: begin
                pre_d     = '0;
                alm_cnt_d = '0;
                if (clear_ev_c) begin
                    reconfig_d = 1'b1;
                end else if (start_ev_c) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (clear_ev_c) begin
                    state_d    = S_IDLE;
                    reconfig_d = 1'b1;
                end else if (zero_in) begin
                    state_d   = S_DONE;
                    pre_d     = '0;
                    alm_cnt_d = '0;
                end else if (pause_ev_c && !start_ev_c) begin
                    // prescaler holds so the resume loses no time
                    state_d = S_PAUSE;
                end else begin
                    pre_d  = pre_inc_c;
                    tick_d = pre_wrap_c;
                end
            end
            S_PAUSE: begin
                if (clear_ev_c) begin
                    state_d    = S_IDLE;
                    reconfig_d = 1'b1;
                end else if (start_ev_c || pause_ev_c) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (clear_ev_c || start_ev_c) begin
                    state_d    = S_IDLE;
                    reconfig_d = 1'b1;
                end else begin
                    pre_d = pre_inc_c;
                    if (pre_wrap_c) begin
                        if (alm_cnt_q == ALM_LAST) begin
                            alm_cnt_d = '0;
`ifdef AUTO_RELOAD_EN
                            state_d    = S_RUN;
                            reconfig_d = 1'b1;
`else
                            state_d = S_IDLE;
`endif
                        end else begin
                            alm_cnt_d = alm_cnt_q + ALM_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        alarm_d   = (state_d == S_DONE);
        running_d = (state_d == S_RUN);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            alm_cnt_q   <= '0;
            tick_q      <= 1'b0;
            reconfig_q  <= 1'b0;
            alarm_q     <= 1'b0;
            running_q   <= 1'b0;
            start_btn_q <= 1'b1;
            pause_btn_q <= 1'b1;
            clear_btn_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            alm_cnt_q   <= alm_cnt_d;
            tick_q      <= tick_d;
            reconfig_q  <= reconfig_d;
            alarm_q     <= alarm_d;
            running_q   <= running_d;
            start_btn_q <= start_btn_d;
            pause_btn_q <= pause_btn_d;
            clear_btn_q <= clear_btn_d;
        end
    end

    assign tick_out     = tick_q;
    assign reconfig_out = reconfig_q;
    assign alarm        = alarm_q;
    assign running      = running_q;
    assign state        = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Testbench for timer_ctrl (TICK_DIV=4, ALARM_TICKS=2): directed scenarios plus random
// stimulus, checked every cycle against a time-based behavioural model.
module tb_timer_ctrl;

    localparam int TD = 4;
    localparam int AT = 2;

    logic       clk;
    logic       rst;
    logic       start_btn, pause_btn, clear_btn, zero_in;
    logic       tick_out, reconfig_out, alarm, running;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // model: mode 0 idle, 1 run, 2 pause, 3 done
    int m_mode  = 0;
    int m_run   = 0;   // counting cycles spent in RUN since the countdown started (mod TD)
    int m_done  = 0;   // cycles spent in DONE
    bit m_tick  = 0;
    bit m_rc    = 0;
    bit p_st = 1, p_pa = 1, p_cl = 1;

    timer_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .pause_btn    (pause_btn),
        .clear_btn    (clear_btn),
        .zero_in      (zero_in),
        .tick_out     (tick_out),
        .reconfig_out (reconfig_out),
        .alarm        (alarm),
        .running      (running),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: one sampled clock edge of elapsed time
    task automatic model_step();
        bit es, ep, ec;
        m_tick = 0;
        m_rc   = 0;
        if (!rst) begin
            m_mode = 0; m_run = 0; m_done = 0;
            p_st = 1; p_pa = 1; p_cl = 1;
            return;
        end
        es = start_btn && !p_st;
        ep = pause_btn && !p_pa;
        ec = clear_btn && !p_cl;
        p_st = start_btn; p_pa = pause_btn; p_cl = clear_btn;
        case (m_mode)
            0: begin
                if (ec) m_rc = 1;
                else if (es) begin m_mode = 1; m_run = 0; end
            end
            1: begin
                if (ec) begin m_mode = 0; m_rc = 1; end
                else if (zero_in) begin m_mode = 3; m_done = 0; end
                else if (ep && !es) m_mode = 2;
                else begin
                    m_run = m_run + 1;
                    if (m_run % TD == 0) m_tick = 1;
                end
            end
            2: begin
                if (ec) begin m_mode = 0; m_rc = 1; end
                else if (es || ep) m_mode = 1;
            end
            default: begin
                if (ec || es) begin m_mode = 0; m_rc = 1; end
                else begin
                    m_done = m_done + 1;
                    if (m_done == TD * AT) begin
`ifdef AUTO_RELOAD_EN
                        m_mode = 1; m_run = 0; m_rc = 1;
`else
                        m_mode = 0;
`endif
                    end
                end
            end
        endcase
    endtask

    task automatic compare();
        chk("state",    int'(state),        m_mode);
        chk("tick",     int'(tick_out),     int'(m_tick));
        chk("reconfig", int'(reconfig_out), int'(m_rc));
        chk("alarm",    int'(alarm),        int'(m_mode == 3));
        chk("running",  int'(running),      int'(m_mode == 1));
    endtask

    // One clock: sample edge, advance model, compare shortly after the edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    initial begin
        rst = 0; start_btn = 0; pause_btn = 0; clear_btn = 0; zero_in = 0;
        cycle();
        chk("rst_state", int'(state), 0);
        chk("rst_alarm", int'(alarm), 0);
        cycle();
        rst = 1;
        cycle();

        // start -> RUN, tick 4 cycles after entry, then every 4
        start_btn = 1;
        cycle();
        chk("start_state", int'(state), 1);
        chk("start_running", int'(running), 1);
        start_btn = 0;
        repeat (3) begin cycle(); chk("early_tick", int'(tick_out), 0); end
        cycle(); chk("first_tick", int'(tick_out), 1);
        repeat (3) begin cycle(); chk("gap_tick", int'(tick_out), 0); end
        cycle(); chk("second_tick", int'(tick_out), 1);

        // clear from RUN, then pause with prescaler at 2 and resume
        clear_btn = 1;
        cycle(); chk("clear_rc", int'(reconfig_out), 1);
        clear_btn = 0; start_btn = 1;
        cycle();
        start_btn = 0;
        cycle(); cycle();
        pause_btn = 1;
        cycle(); chk("paused_state", int'(state), 2);
        pause_btn = 0;
        repeat (10) begin cycle(); chk("paused_tick", int'(tick_out), 0); end
        pause_btn = 1;
        cycle(); chk("resume_state", int'(state), 1);
        pause_btn = 0;
        cycle(); chk("resume_tick1", int'(tick_out), 0);
        cycle(); chk("resume_tick2", int'(tick_out), 1);

        // expiry and alarm duration
        zero_in = 1;
        cycle();
        chk("done_state", int'(state), 3);
        chk("done_alarm", int'(alarm), 1);
        zero_in = 0;
        repeat (7) begin cycle(); chk("alarm_hold", int'(alarm), 1); end
        cycle();
        chk("alarm_end", int'(alarm), 0);
`ifdef AUTO_RELOAD_EN
        chk("auto_state", int'(state), 1);
        chk("auto_rc", int'(reconfig_out), 1);
`else
        chk("end_state", int'(state), 0);
        chk("end_rc", int'(reconfig_out), 0);
`endif

        // clear and start together in RUN
        start_btn = 1; cycle(); start_btn = 0; cycle(); cycle();
        clear_btn = 1; start_btn = 1;
        cycle();
        chk("cs_state", int'(state), 0);
        chk("cs_rc", int'(reconfig_out), 1);
        chk("cs_tick", int'(tick_out), 0);
        clear_btn = 0; start_btn = 0;
        cycle(); chk("cs_rc_once", int'(reconfig_out), 0);

        // reset while alarm active
        start_btn = 1; cycle(); start_btn = 0; cycle();
        zero_in = 1; cycle(); zero_in = 0;
        cycle(); chk("pre_rst_alarm", int'(alarm), 1);
        rst = 0;
        cycle();
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_alarm", int'(alarm), 0);
        chk("mid_rst_rc", int'(reconfig_out), 0);

        // start held across reset release
        start_btn = 1; cycle();
        rst = 1;
        repeat (3) begin cycle(); chk("held_idle", int'(state), 0); end
        start_btn = 0; cycle();
        start_btn = 1; cycle(); chk("repress_run", int'(state), 1);
        start_btn = 0;

        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            start_btn = ($urandom_range(0, 9) == 0);
            pause_btn = ($urandom_range(0, 9) == 0);
            clear_btn = ($urandom_range(0, 24) == 0);
            zero_in   = ($urandom_range(0, 29) == 0);
            rst       = !($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
